// File: rtl/sample_iterator_if.sv
// Triangle-in / sample-out bundle between the bbox stage, the sample iterator and the sample tester.
// The iterator connects through the slave modport; whatever drives triangles uses master.
interface sample_iterator_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R13U [COLORS];
    logic signed [SIGFIG-1:0] box_R13S [2][2];
    logic                     validTri_R13H;
    logic        [3:0]        subSample_RnnnnU;
    logic                     halt_RnnnnL;
    logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R14U [COLORS];
    logic signed [SIGFIG-1:0] sample_R14S [2];
    logic                     validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/sample_iterator.sv
// Walks every step-grid sample inside a triangle's bounding box, one sample per cycle,
// in x-then-y order, holding the triangle and its color alongside each sample.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic             clk,
    input  logic             rst,
    sample_iterator_if.slave bus
);
    typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic                     valid_q, valid_d;
    logic signed [SIGFIG-1:0] sample_q [2];
    logic signed [SIGFIG-1:0] sample_d [2];
    logic signed [SIGFIG-1:0] ll_q [2];
    logic signed [SIGFIG-1:0] ll_d [2];
    logic signed [SIGFIG-1:0] ur_q [2];
    logic signed [SIGFIG-1:0] ur_d [2];
    logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
    logic signed [SIGFIG-1:0] tri_d [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q [COLORS];
    logic        [SIGFIG-1:0] color_d [COLORS];
    logic signed [SIGFIG:0]   step_w;
    logic                     accept;
    logic                     x_wrap;
    logic                     next_last;

    // One guard bit so x+step at the top of the coordinate range cannot wrap negative.
    function automatic logic signed [SIGFIG:0] widen(input logic signed [SIGFIG-1:0] v);
        return {v[SIGFIG-1], v};
    endfunction

    always_comb begin
        step_w = '0;
        if (bus.subSample_RnnnnU[3])      step_w[RADIX]   = 1'b1;
        else if (bus.subSample_RnnnnU[2]) step_w[RADIX-1] = 1'b1;
        else if (bus.subSample_RnnnnU[1]) step_w[RADIX-2] = 1'b1;
        else                              step_w[RADIX-3] = 1'b1;
    end

    assign bus.halt_RnnnnL = (state_q == WAIT);
    assign accept          = bus.validTri_R13H && (state_q == WAIT);
    assign x_wrap          = (widen(sample_q[0]) + step_w) > widen(ur_q[0]);

    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        sample_d  = sample_q;
        ll_d      = ll_q;
        ur_d      = ur_q;
        tri_d     = tri_q;
        color_d   = color_q;
        next_last = 1'b0;
        if (state_q == TEST) begin
            valid_d = 1'b1;
            if (x_wrap) begin
                sample_d[0] = ll_q[0];
                sample_d[1] = sample_q[1] + step_w[SIGFIG-1:0];
            end else begin
                sample_d[0] = sample_q[0] + step_w[SIGFIG-1:0];
            end
        end else if (accept) begin
            valid_d  = 1'b1;
            sample_d = bus.box_R13S[0];
            ll_d     = bus.box_R13S[0];
            ur_d     = bus.box_R13S[1];
            tri_d    = bus.tri_R13S;
            color_d  = bus.color_R13U;
        end
        // State tracks whether the sample about to be shown is the box's last one,
        // so halt is already released while that sample sits on the output.
        next_last = ((widen(sample_d[0]) + step_w) > widen(ur_d[0])) &&
                    ((widen(sample_d[1]) + step_w) > widen(ur_d[1]));
        if (valid_d) state_d = next_last ? WAIT : TEST;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= WAIT;
            valid_q  <= 1'b0;
            sample_q <= '{default: '0};
            ll_q     <= '{default: '0};
            ur_q     <= '{default: '0};
            tri_q    <= '{default: '{default: '0}};
            color_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            ll_q     <= ll_d;
            ur_q     <= ur_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
        end
    end

    assign bus.validSamp_R14H = valid_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < VERTS; gi++) begin : g_tri_v
            for (gj = 0; gj < AXIS; gj++) begin : g_tri_a
                assign bus.tri_R14S[gi][gj] = tri_q[gi][gj];
            end
        end
        for (gi = 0; gi < COLORS; gi++) begin : g_color
            assign bus.color_R14U[gi] = color_q[gi];
        end
        for (gi = 0; gi < 2; gi++) begin : g_sample
            assign bus.sample_R14S[gi] = sample_q[gi];
        end
    endgenerate
endmodule

// File: tb/tb_sample_iterator.sv
// Directed plus randomized triangles against a queue of expected samples built from nested box loops.
module tb_sample_iterator;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sample_iterator_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

    sample_iterator #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int x;
        int y;
        int tag;
    } samp_t;

    samp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int nsamp  = 0;
    int last_x = 0;
    int last_y = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int step_of(input logic [3:0] sub);
        if (sub[3]) return 1024;
        if (sub[2]) return 512;
        if (sub[1]) return 256;
        return 128;
    endfunction

    // Drives one triangle; the model records its samples only if the DUT is idle (will accept).
    task automatic present(input bit vld, input int tag, input int llx, input int lly,
                           input int urx, input int ury, input logic [3:0] sub);
        int stp;
        stp = step_of(sub);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                bus.tri_R13S[v][a] = SIGFIG'(tag * 16 + v * 3 + a);
        for (int c = 0; c < COLORS; c++) bus.color_R13U[c] = SIGFIG'(tag * 8 + c);
        bus.box_R13S[0][0] = SIGFIG'(llx);
        bus.box_R13S[0][1] = SIGFIG'(lly);
        bus.box_R13S[1][0] = SIGFIG'(urx);
        bus.box_R13S[1][1] = SIGFIG'(ury);
        bus.validTri_R13H  = vld;
        if (exp_q.size() == 0) begin
            bus.subSample_RnnnnU = sub;
            if (vld && rst)
                for (int y = lly; y <= ury; y += stp)
                    for (int x = llx; x <= urx; x += stp)
                        exp_q.push_back('{x: x, y: y, tag: tag});
        end
    endtask

    task automatic tick();
        samp_t e;
        bit ve;
        @(negedge clk);
        ve = (exp_q.size() != 0);
        chk("valid", bus.validSamp_R14H, ve);
        if (ve) begin
            e = exp_q.pop_front();
            if (bus.validSamp_R14H === 1'b1) begin
                nsamp++;
                last_x = int'(bus.sample_R14S[0]);
                last_y = int'(bus.sample_R14S[1]);
            end
            chk("sample_x", bus.sample_R14S[0], e.x);
            chk("sample_y", bus.sample_R14S[1], e.y);
            chk("tri_first", bus.tri_R14S[0][0], e.tag * 16);
            chk("tri_last", bus.tri_R14S[VERTS-1][AXIS-1], e.tag * 16 + (VERTS-1) * 3 + AXIS - 1);
            chk("color", bus.color_R14U[COLORS-1], e.tag * 8 + COLORS - 1);
        end
        chk("halt", bus.halt_RnnnnL, (exp_q.size() == 0));
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        bus.validTri_R13H = 1'b0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_bound", exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        int stp;
        int nx;
        int ny;
        int llx;
        int lly;
        logic [3:0] sub;

        present(1'b0, 0, 0, 0, 0, 0, 4'b1000);
        repeat (3) tick();
        chk("rst_sample_x", bus.sample_R14S[0], 0);
        chk("rst_sample_y", bus.sample_R14S[1], 0);
        chk("rst_tri", bus.tri_R14S[1][1], 0);
        chk("rst_color", bus.color_R14U[0], 0);

        // MSAA1, accepted on the very first cycle out of reset
        rst = 1'b1;
        n0 = nsamp;
        present(1'b1, 1, 0, 0, 2048, 1024, 4'b1000);
        tick();
        drain(50);
        chk("msaa1_count", nsamp - n0, 6);
        chk("msaa1_last_x", last_x, 2048);
        chk("msaa1_last_y", last_y, 1024);

        // MSAA4
        n0 = nsamp;
        present(1'b1, 2, 1024, 1024, 1536, 1536, 4'b0100);
        tick();
        drain(50);
        chk("msaa4_count", nsamp - n0, 4);

        // degenerate boxes back to back
        n0 = nsamp;
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 3 + i, 3072, 2048, 3072, 2048, 4'b1000);
            tick();
        end
        bus.validTri_R13H = 1'b0;
        tick();
        chk("degen_count", nsamp - n0, 3);

        // new triangles offered mid-traversal must be ignored
        n0 = nsamp;
        present(1'b1, 6, 0, 0, 2048, 1024, 4'b1000);
        tick();
        for (int i = 0; i < 4; i++) begin
            present((i % 2) == 0, 7 + i, 1024, 0, 3072, 3072, 4'b1000);
            tick();
        end
        drain(50);
        chk("ignore_count", nsamp - n0, 6);

        // reset after the second sample abandons the triangle
        present(1'b1, 12, 0, 0, 2048, 1024, 4'b1000);
        tick();
        tick();
        rst = 1'b0;
        bus.validTri_R13H = 1'b0;
        exp_q.delete();
        tick();
        chk("midrst_sample", bus.sample_R14S[0], 0);
        chk("midrst_tri", bus.tri_R14S[0][0], 0);
        rst = 1'b1;
        n0 = nsamp;
        repeat (6) tick();
        chk("midrst_residual", nsamp - n0, 0);

        // MSAA64
        n0 = nsamp;
        present(1'b1, 13, 0, 0, 1024, 1024, 4'b0001);
        tick();
        drain(200);
        chk("msaa64_count", nsamp - n0, ((1024 - 0) / 128 + 1) * ((1024 - 0) / 128 + 1));
        chk("msaa64_last_x", last_x, 1024);
        chk("msaa64_last_y", last_y, 1024);

        // top of the positive coordinate range
        n0 = nsamp;
        present(1'b1, 14, 8386560, 8386560, 8387584, 8387584, 4'b1000);
        tick();
        drain(50);
        chk("limit_count", nsamp - n0, 4);

        // random boxes, rates and idle gaps (zero gap exercises the no-bubble handoff)
        for (int t = 0; t < 40; t++) begin
            sub = 4'b0001 << $urandom_range(0, 3);
            stp = step_of(sub);
            nx  = int'($urandom_range(0, 3));
            ny  = int'($urandom_range(0, 3));
            llx = (int'($urandom_range(0, 16)) - 8) * stp;
            lly = (int'($urandom_range(0, 16)) - 8) * stp;
            n0  = nsamp;
            present(1'b1, 15 + t, llx, lly, llx + nx * stp, lly + ny * stp, sub);
            tick();
            drain(50);
            chk("rand_count", nsamp - n0, (nx + 1) * (ny + 1));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
